// File: rtl/muldiv_seq_pkg.sv
// Shared types for the sequential multiply/divide unit.
package muldiv_seq_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef enum logic {
    MD_OP_MUL = 1'b0,
    MD_OP_DIV = 1'b1
  } md_op_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the EX stage (master) and the mul/div unit (slave).
interface muldiv_seq_if
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic                 start_i;
  logic                 annul_i;
  md_op_e               op_i;
  logic                 signed_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 busy_o;
  logic                 div_zero_o;

  modport master (
    output start_i, annul_i, op_i, signed_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, busy_o, div_zero_o
  );

  modport slave (
    input  start_i, annul_i, op_i, signed_i, opdata1_i, opdata2_i,
    output result_o, ready_o, busy_o, div_zero_o
  );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide unit: one product or quotient bit per cycle.
// WIDTH must be >= 2.
//
// state   | meaning
// --------+-----------------------------------------------------------
// MD_IDLE | waiting for start_i; outputs cleared
// MD_RUN  | iterating on operand magnitudes, busy_o high
// MD_DONE | result_o valid, ready_o high until start_i drops or annul_i
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  muldiv_seq_if.slave   md_if
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_e            state_q;
  md_op_e               op_q;
  logic [CNT_W-1:0]     cnt_q;
  // mul: {partial hi, remaining multiplier bits}; div: {partial remainder, dividend/quotient bits}
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]     oper_q;
  logic                 neg_q;
  logic                 rem_neg_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 dz_q;

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_diff;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;
  logic [2*WIDTH-1:0]   fix_res;

  // Two's complement magnitude; unsigned operands pass through untouched.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  // One iteration of shift-add / restoring shift-subtract, plus the signed fix-up
  // applied to the post-iteration value so the last step and fix-up share a cycle.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, oper_q} : '0);
    // Partial remainder shifted left with the next dividend bit; a set bit WIDTH means borrow.
    div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, oper_q};
    if (op_q == MD_OP_MUL) begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
    end
    quo = acc_d[WIDTH-1:0];
    rem = acc_d[2*WIDTH-1:WIDTH];
    if (op_q == MD_OP_MUL) begin
      fix_res = neg_q ? -acc_d : acc_d;
    end else begin
      fix_res = {(rem_neg_q ? -rem : rem), (neg_q ? -quo : quo)};
    end
  end

  // Control FSM with registered outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      op_q      <= MD_OP_MUL;
      cnt_q     <= '0;
      acc_q     <= '0;
      oper_q    <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (md_if.start_i && !md_if.annul_i) begin
            if (md_if.op_i == MD_OP_DIV && md_if.opdata2_i == '0) begin
              state_q  <= MD_DONE;
              result_q <= '0;
              ready_q  <= 1'b1;
              dz_q     <= 1'b1;
            end else begin
              state_q   <= MD_RUN;
              busy_q    <= 1'b1;
              op_q      <= md_if.op_i;
              cnt_q     <= '0;
              acc_q     <= {{WIDTH{1'b0}}, mag(md_if.opdata1_i, md_if.signed_i)};
              oper_q    <= mag(md_if.opdata2_i, md_if.signed_i);
              neg_q     <= md_if.signed_i & (md_if.opdata1_i[WIDTH-1] ^ md_if.opdata2_i[WIDTH-1]);
              rem_neg_q <= md_if.signed_i & md_if.opdata1_i[WIDTH-1];
            end
          end
        end
        MD_RUN: begin
          if (md_if.annul_i || !md_if.start_i) begin
            state_q <= MD_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_q  <= MD_DONE;
              busy_q   <= 1'b0;
              ready_q  <= 1'b1;
              result_q <= fix_res;
            end
          end
        end
        MD_DONE: begin
          if (md_if.annul_i || !md_if.start_i) begin
            state_q  <= MD_IDLE;
            ready_q  <= 1'b0;
            result_q <= '0;
            dz_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign md_if.result_o   = result_q;
  assign md_if.ready_o    = ready_q;
  assign md_if.busy_o     = busy_q;
  assign md_if.div_zero_o = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed WIDTH=32 cases plus randomized WIDTH=8 traffic
// checked against an integer-arithmetic reference model.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_seq_if #(.WIDTH(32)) if32();
  muldiv_seq_if #(.WIDTH(8))  if8();

  muldiv_seq #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .md_if(if32.slave));
  muldiv_seq #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .md_if(if8.slave));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns {div_zero, {hi,lo}} for a w-bit operation using plain integer arithmetic.
  function automatic logic [64:0] ref_md(input int w, input bit op, input bit sgn,
                                         input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r, p;
    logic [63:0] mw, m2, uq, ur, up;
    mw = (64'd1 << w) - 64'd1;
    m2 = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    sa = longint'({32'b0, a} & mw);
    sb = longint'({32'b0, b} & mw);
    if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
    if (!op) begin
      p  = sa * sb;
      up = p;
      return {1'b0, up & m2};
    end
    if (sb == 0) return {1'b1, 64'd0};
    q  = sa / sb;
    r  = sa % sb;
    uq = q;
    ur = r;
    return {1'b0, ((ur & mw) << w) | (uq & mw)};
  endfunction

  task automatic run32(input string tag, input bit op, input bit sgn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_res, input bit exp_dz, input bit release_after);
    int n, busy_n;
    bit seen;
    @(negedge clk);
    if32.start_i   = 1'b1;
    if32.op_i      = md_op_e'(op);
    if32.signed_i  = sgn;
    if32.opdata1_i = a;
    if32.opdata2_i = b;
    n = 0; busy_n = 0; seen = 1'b0;
    while (!seen && n < 45) begin
      @(negedge clk);
      n++;
      if (if32.busy_o) busy_n++;
      if (if32.ready_o) seen = 1'b1;
    end
    chk({tag, " latency"}, 64'(n), exp_dz ? 64'd1 : 64'd33);
    chk({tag, " busy_cycles"}, 64'(busy_n), exp_dz ? 64'd0 : 64'd32);
    chk({tag, " result"}, if32.result_o, exp_res);
    chk({tag, " div_zero"}, 64'(if32.div_zero_o), 64'(exp_dz));
    chk({tag, " model"}, 64'(ref_md(32, op, sgn, a, b)), exp_res);
    @(negedge clk);
    chk({tag, " hold"}, {if32.ready_o, if32.result_o[62:0]}, {1'b1, exp_res[62:0]});
    if (release_after) begin
      if32.start_i = 1'b0;
      @(negedge clk);
      chk({tag, " release"}, {if32.ready_o, if32.busy_o, if32.div_zero_o, if32.result_o[60:0]}, 64'd0);
    end
  endtask

  task automatic run8(input int idx, input bit op, input bit sgn,
                      input logic [7:0] a, input logic [7:0] b);
    logic [64:0] e;
    int n;
    bit seen;
    e = ref_md(8, op, sgn, {24'b0, a}, {24'b0, b});
    @(negedge clk);
    if8.start_i   = 1'b1;
    if8.op_i      = md_op_e'(op);
    if8.signed_i  = sgn;
    if8.opdata1_i = a;
    if8.opdata2_i = b;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      chk($sformatf("w8 #%0d busy@%0d", idx, n), 64'(if8.busy_o), 64'(!e[64] && n <= 8));
      if (if8.ready_o) seen = 1'b1;
    end
    chk($sformatf("w8 #%0d latency", idx), 64'(n), e[64] ? 64'd1 : 64'd9);
    chk($sformatf("w8 #%0d op=%0d s=%0d a=%h b=%h result", idx, op, sgn, a, b),
        64'(if8.result_o), {48'd0, e[15:0]});
    chk($sformatf("w8 #%0d div_zero", idx), 64'(if8.div_zero_o), 64'(e[64]));
    if8.start_i = 1'b0;
    @(negedge clk);
    chk($sformatf("w8 #%0d release", idx), {62'd0, if8.ready_o, if8.div_zero_o}, 64'd0);
  endtask

  initial begin
    int rdy_cnt;
    rst = 1'b1;
    if32.start_i = 1'b0; if32.annul_i = 1'b0; if32.op_i = MD_OP_MUL;
    if32.signed_i = 1'b0; if32.opdata1_i = '0; if32.opdata2_i = '0;
    if8.start_i = 1'b0; if8.annul_i = 1'b0; if8.op_i = MD_OP_MUL;
    if8.signed_i = 1'b0; if8.opdata1_i = '0; if8.opdata2_i = '0;
    repeat (3) @(negedge clk);
    chk("reset result", if32.result_o, 64'd0);
    chk("reset flags", {61'd0, if32.ready_o, if32.busy_o, if32.div_zero_o}, 64'd0);
    chk("reset w8", {if8.ready_o, if8.busy_o, if8.div_zero_o, if8.result_o}, 64'd0);
    rst = 1'b0;

    // Model pins against hand-computed values.
    chk("model smul -3*5", 64'(ref_md(32, 1'b0, 1'b1, 32'hFFFFFFFD, 32'd5)), 64'hFFFFFFFF_FFFFFFF1);
    chk("model w8 sdiv min/-1", 64'(ref_md(8, 1'b1, 1'b1, 32'h80, 32'hFF)), 64'h0000_0080);
    chk("model w8 udiv 200/7", 64'(ref_md(8, 1'b1, 1'b0, 32'd200, 32'd7)), 64'h041C);

    run32("umul max", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 1'b1);
    run32("sdiv -7/2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 1'b1);
    run32("sdiv min/-1", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 1'b1);
    run32("udiv 7/2 hi-bit", 1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 1'b0, 1'b1);
    run32("smul -3*5", 1'b0, 1'b1, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b0, 1'b1);
    run32("div 5/0", 1'b1, 1'b0, 32'd5, 32'd0, 64'd0, 1'b1, 1'b1);

    // Abort at RUN cycle 10.
    @(negedge clk);
    if32.start_i = 1'b1; if32.op_i = MD_OP_MUL; if32.signed_i = 1'b0;
    if32.opdata1_i = 32'd1234; if32.opdata2_i = 32'd5678;
    repeat (10) @(negedge clk);
    chk("abort busy before", 64'(if32.busy_o), 64'd1);
    if32.annul_i = 1'b1;
    @(negedge clk);
    chk("abort next cycle", {if32.ready_o, if32.busy_o, if32.result_o[61:0]}, 64'd0);
    if32.start_i = 1'b0; if32.annul_i = 1'b0;
    rdy_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (if32.ready_o) rdy_cnt++;
    end
    chk("abort ready never", 64'(rdy_cnt), 64'd0);
    run32("after abort", 1'b0, 1'b0, 32'd1234, 32'd5678, 64'd7006652, 1'b0, 1'b1);

    // start and annul together in IDLE: annul wins.
    @(negedge clk);
    if32.start_i = 1'b1; if32.annul_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("start+annul idle", {62'd0, if32.ready_o, if32.busy_o}, 64'd0);
    if32.start_i = 1'b0; if32.annul_i = 1'b0;

    // Reset mid-RUN with start held.
    @(negedge clk);
    if32.start_i = 1'b1; if32.op_i = MD_OP_DIV; if32.signed_i = 1'b1;
    if32.opdata1_i = 32'd1000; if32.opdata2_i = 32'd3;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst mid-run", {if32.ready_o, if32.busy_o, if32.div_zero_o, if32.result_o[60:0]}, 64'd0);
    @(negedge clk);
    chk("rst ignores start", {62'd0, if32.ready_o, if32.busy_o}, 64'd0);
    if32.start_i = 1'b0; rst = 1'b0;

    // Reset in DONE.
    run32("umul pre-rst", 1'b0, 1'b0, 32'd65536, 32'd65536, 64'h00000001_00000000, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst in done", {if32.ready_o, if32.busy_o, if32.div_zero_o, if32.result_o[60:0]}, 64'd0);
    chk("rst in done hi", 64'(if32.result_o[63:61]), 64'd0);
    if32.start_i = 1'b0; rst = 1'b0;

    // Randomized WIDTH=8 traffic.
    for (int i = 0; i < 1000; i++) begin
      bit op, sgn;
      logic [7:0] a, b;
      op  = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      a   = 8'($urandom_range(0, 255));
      b   = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (i == 0) begin op = 1'b1; sgn = 1'b1; a = 8'h80; b = 8'hFF; end
      if (i == 1) begin op = 1'b0; sgn = 1'b1; a = 8'h80; b = 8'h80; end
      run8(i, op, sgn, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
